vga_fill_ctrl: RTL



---
 rtl/vga_fill_pkg.sv | 30 +++
 rtl/vga_fill_ctrl_if.sv | 24 ++
 rtl/vga_fill_rect_gen.sv | 83 ++++++++
 rtl/vga_fill_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fill_pkg.sv
// rtl/vga_fill_pkg.sv - shared constants and types for the VGA fill controller
package vga_fill_pkg;

  localparam int FB_AW     = 16;
  localparam int FB_DW     = 8;
  localparam int LINE_BITS = 8;
  localparam int FB_W      = 256;

  localparam logic [3:0] REG_PTR     = 4'd0;
  localparam logic [3:0] REG_PIX     = 4'd1;
  localparam logic [3:0] REG_RECT_XY = 4'd2;
  localparam logic [3:0] REG_RECT_WH = 4'd3;
  localparam logic [3:0] REG_COLOR   = 4'd4;
  localparam logic [3:0] REG_CTRL    = 4'd5;
  localparam logic [3:0] REG_STATUS  = 4'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ABORTED = 2;
  localparam int STAT_DROP    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/vga_fill_ctrl_if.sv
// rtl/vga_fill_ctrl_if.sv - register bus and framebuffer write port bundle
interface vga_fill_ctrl_if #(
  parameter int FB_AW = 16,
  parameter int FB_DW = 8
);
  logic             valid;
  logic [3:0]       addr;
  logic [31:0]      wdata;
  logic             wstrb;
  logic [31:0]      rdata;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [FB_DW-1:0] fb_wdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  rdata, fb_we, fb_addr, fb_wdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output rdata, fb_we, fb_addr, fb_wdata
  );
endinterface

// File: rtl/vga_fill_rect_gen.sv
// rtl/vga_fill_rect_gen.sv - rectangle walker: column/row counters with independent wrap
module vga_fill_rect_gen #(
  parameter int COL_W = 8,
  parameter int ROW_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [COL_W-1:0] x0_i,
  input  logic [ROW_W-1:0] y0_i,
  input  logic [COL_W:0]   w_i,
  input  logic [ROW_W:0]   h_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [COL_W:0] ONE_C = {{COL_W{1'b0}}, 1'b1};
  localparam logic [ROW_W:0] ONE_R = {{ROW_W{1'b0}}, 1'b1};

  logic [COL_W-1:0] col_q, col_d, x0_q, x0_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W:0]   w_q, w_d, i_q, i_d;
  logic [ROW_W:0]   h_q, h_d, j_q, j_d;
  logic             last_col;

  assign last_col = (i_q == (w_q - ONE_C));
  assign last_o   = last_col && (j_q == (h_q - ONE_R));
  assign col_o    = col_q;
  assign row_o    = row_q;

  // Column wraps inside the row on its own; the row only advances at end of a span.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    x0_d  = x0_q;
    w_d   = w_q;
    h_d   = h_q;
    i_d   = i_q;
    j_d   = j_q;
    if (load_i) begin
      col_d = x0_i;
      row_d = y0_i;
      x0_d  = x0_i;
      w_d   = w_i;
      h_d   = h_i;
      i_d   = '0;
      j_d   = '0;
    end else if (step_i) begin
      if (last_col) begin
        i_d   = '0;
        col_d = x0_q;
        j_d   = j_q + ONE_R;
        row_d = row_q + 1'b1;
      end else begin
        i_d   = i_q + ONE_C;
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      x0_q  <= '0;
      w_q   <= '0;
      h_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      x0_q  <= x0_d;
      w_q   <= w_d;
      h_q   <= h_d;
      i_q   <= i_d;
      j_q   <= j_d;
    end
  end

endmodule

// File: rtl/vga_fill_ctrl.sv
// rtl/vga_fill_ctrl.sv - framebuffer write sequencer: CPU pixel writes plus rectangle fill engine
module vga_fill_ctrl
  import vga_fill_pkg::*;
#(
  parameter int FB_AW     = 16,
  parameter int FB_DW     = 8,
  parameter int LINE_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  vga_fill_ctrl_if.slave    bus,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = LINE_BITS;
  localparam int ROW_W = FB_AW - LINE_BITS;
  localparam logic [COL_W:0] W_MAX = {1'b1, {COL_W{1'b0}}};
  localparam logic [ROW_W:0] H_MAX = {1'b1, {ROW_W{1'b0}}};

  fill_state_e      state_q, state_d;
  logic [FB_AW-1:0] ptr_q, ptr_d, pix_addr_q, pix_addr_d;
  logic [FB_DW-1:0] pix_data_q, pix_data_d;
  logic [FB_DW-1:0] color_q, color_d, fill_color_q, fill_color_d;
  logic [COL_W-1:0] x0_q, x0_d;
  logic [ROW_W-1:0] y0_q, y0_d;
  logic [COL_W:0]   w_q, w_d, w_in;
  logic [ROW_W:0]   h_q, h_d, h_in;
  logic             done_q, done_d, aborted_q, aborted_d, drop_q, drop_d;
  logic             pix_we_q, pix_we_d;
  logic [31:0]      rdata_q, rdata_d, rd_val;

  logic             wr, rd, wr_ctrl, start_req, abort_req, filling;
  logic             gen_load, gen_step, gen_last;
  logic             fill_start, fill_done, fill_abort, zero_done;
  logic [COL_W-1:0] gen_col;
  logic [ROW_W-1:0] gen_row;
  logic             unused_wdata;

  assign wr        = bus.valid && bus.wstrb;
  assign rd        = bus.valid && !bus.wstrb;
  assign wr_ctrl   = wr && (bus.addr == REG_CTRL);
  assign abort_req = wr_ctrl && bus.wdata[CTRL_ABORT];
  assign start_req = wr_ctrl && bus.wdata[CTRL_START] && !bus.wdata[CTRL_ABORT];
  assign filling   = (state_q == ST_FILL);
  assign unused_wdata = ^bus.wdata;

  assign w_in = (bus.wdata[COL_W:0] > W_MAX) ? W_MAX : bus.wdata[COL_W:0];
  assign h_in = (bus.wdata[16 +: ROW_W+1] > H_MAX) ? H_MAX : bus.wdata[16 +: ROW_W+1];

  vga_fill_rect_gen #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_rect_gen (
    .clk    (clk),
    .reset  (reset),
    .load_i (gen_load),
    .step_i (gen_step),
    .x0_i   (x0_q),
    .y0_i   (y0_q),
    .w_i    (w_q),
    .h_i    (h_q),
    .col_o  (gen_col),
    .row_o  (gen_row),
    .last_o (gen_last)
  );

  always_comb begin
    state_d    = state_q;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    fill_abort = 1'b0;
    zero_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if ((w_q == '0) || (h_q == '0)) begin
            zero_done = 1'b1;
          end else begin
            gen_load   = 1'b1;
            fill_start = 1'b1;
            state_d    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        gen_step = 1'b1;
        if (abort_req) begin
          fill_abort = 1'b1;
          state_d    = ST_IDLE;
        end else if (gen_last) begin
          fill_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d        = ptr_q;
    pix_we_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    fill_color_d = fill_color_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    drop_d       = drop_q;
    if (wr) begin
      case (bus.addr)
        REG_PTR:     ptr_d = bus.wdata[FB_AW-1:0];
        REG_PIX: begin
          // The fill engine owns the port while busy; CPU pixels are lost, not queued.
          if (filling) begin
            drop_d = 1'b1;
          end else begin
            pix_we_d   = 1'b1;
            pix_addr_d = ptr_q;
            pix_data_d = bus.wdata[FB_DW-1:0];
            ptr_d      = ptr_q + 1'b1;
          end
        end
        REG_RECT_XY: begin
          x0_d = bus.wdata[COL_W-1:0];
          y0_d = bus.wdata[8 +: ROW_W];
        end
        REG_RECT_WH: begin
          w_d = w_in;
          h_d = h_in;
        end
        REG_COLOR:   color_d = bus.wdata[FB_DW-1:0];
        REG_STATUS: begin
          if (bus.wdata[STAT_DONE])    done_d    = 1'b0;
          if (bus.wdata[STAT_ABORTED]) aborted_d = 1'b0;
          if (bus.wdata[STAT_DROP])    drop_d    = 1'b0;
        end
        default: ;
      endcase
    end
    if (fill_start) begin
      done_d       = 1'b0;
      aborted_d    = 1'b0;
      fill_color_d = color_q;
    end
    if (zero_done) begin
      done_d    = 1'b1;
      aborted_d = 1'b0;
    end
    if (fill_done)  done_d    = 1'b1;
    if (fill_abort) aborted_d = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      REG_PTR:     rd_val[FB_AW-1:0] = ptr_q;
      REG_RECT_XY: begin
        rd_val[COL_W-1:0]  = x0_q;
        rd_val[8 +: ROW_W] = y0_q;
      end
      REG_RECT_WH: begin
        rd_val[COL_W:0]      = w_q;
        rd_val[16 +: ROW_W+1] = h_q;
      end
      REG_COLOR:   rd_val[FB_DW-1:0] = color_q;
      REG_STATUS: begin
        rd_val[STAT_BUSY]    = filling;
        rd_val[STAT_DONE]    = done_q;
        rd_val[STAT_ABORTED] = aborted_q;
        rd_val[STAT_DROP]    = drop_q;
      end
      default: rd_val = '0;
    endcase
    rdata_d = rd ? rd_val : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      pix_we_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      fill_color_q <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      drop_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pix_we_q     <= pix_we_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      color_q      <= color_d;
      fill_color_q <= fill_color_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      drop_q       <= drop_d;
      rdata_q      <= rdata_d;
    end
  end

  // Port outputs are steered from registers only, so they never depend on the bus this cycle.
  assign bus.fb_we    = filling || pix_we_q;
  assign bus.fb_addr  = filling ? {gen_row, gen_col} : pix_addr_q;
  assign bus.fb_wdata = filling ? fill_color_q : pix_data_q;
  assign bus.rdata    = rdata_q;
  assign busy         = filling;
  assign done         = done_q;

endmodule
